// File: rtl/rv32i_types.sv
// Shared types for the perf counter window: counter offsets, handshake states, index helper.
package rv32i_types;

  localparam int PERF_NUM_COUNTERS = 11;

  // Byte offsets inside the perf window; software headers derive from this list.
  typedef enum logic [7:0] {
    ICACHE_HIT   = 8'h00,
    ICACHE_MISS  = 8'h04,
    DCACHE_HIT   = 8'h08,
    DCACHE_MISS  = 8'h0C,
    L2_HIT       = 8'h10,
    L2_MISS      = 8'h14,
    EWB_WRITE    = 8'h18,
    BR_TOTAL     = 8'h1C,
    BR_INCORRECT = 8'h20,
    PF_HIT       = 8'h24,
    PF_READ      = 8'h28
  } counter_addr;

  typedef enum logic {
    PERF_IDLE,
    PERF_RESP
  } perf_state_t;

  function automatic logic [5:0] counter_addr_to_idx(input logic [7:0] addr);
    return 6'(addr >> 2);
  endfunction

endpackage

// File: rtl/perf_counter.sv
// One saturating event counter with a byte-masked load port.
// A load in the same edge as an increment wins and the increment is dropped.
module perf_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  input  logic                 load_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          cur_ext;
  logic [31:0]          merged;

  always_comb begin
    cur_ext = 32'(cnt_q);
    merged  = cur_ext;
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
    end
    cnt_d = cnt_q;
    // Upper store bits beyond the counter width fall away on truncation.
    if (load_i) begin
      cnt_d = merged[CNT_WIDTH-1:0];
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Memory-mapped bank of saturating performance counters behind a fixed 256-byte window.
// Each accepted load/store completes with a single mem_resp pulse one cycle after sampling.
module perf_counter_unit
  import rv32i_types::*;
#(
  parameter int          NUM_COUNTERS = PERF_NUM_COUNTERS,
  parameter int          CNT_WIDTH    = 32,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    count_en,
  input  logic [NUM_COUNTERS-1:0] event_i,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [31:0]             mem_address,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_byte_enable,
  output logic                    sel_o,
  output logic [31:0]             mem_rdata,
  output logic                    mem_resp
);

  perf_state_t          state_q, state_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0] cnt [NUM_COUNTERS];
  logic [5:0]           idx;
  logic                 mapped;
  logic                 accept;
  logic                 do_wr;
  logic                 do_rd;
  logic [31:0]          rd_val;

  assign sel_o  = (mem_address[31:8] == BASE_ADDR[31:8]);
  assign idx    = counter_addr_to_idx(mem_address[7:0]);
  assign mapped = (mem_address[1:0] == 2'b00) && (int'(idx) < NUM_COUNTERS);
  assign accept = (state_q == PERF_IDLE) && (mem_read || mem_write) && sel_o;
  // A combined read+write is serviced as a write only.
  assign do_wr  = accept && mem_write;
  assign do_rd  = accept && mem_read && !mem_write;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (mapped && (idx == 6'(i))) rd_val = 32'(cnt[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      PERF_IDLE: begin
        if (accept) state_d = PERF_RESP;
        if (do_rd)  rdata_d = rd_val;
      end
      PERF_RESP: state_d = PERF_IDLE;
      default:   state_d = PERF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PERF_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_resp  = (state_q == PERF_RESP);
  assign mem_rdata = rdata_q;

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
    perf_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (count_en && event_i[g]),
      .load_i  (do_wr && mapped && (idx == 6'(g))),
      .be_i    (mem_byte_enable),
      .wdata_i (mem_wdata),
      .cnt_o   (cnt[g])
    );
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: a 32-bit bank and a 4-bit bank share one bus.
module tb_perf_counter_unit;

  localparam int          NC   = 11;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          count_en;
  logic [NC-1:0] event_i;
  logic          mem_read, mem_write;
  logic [31:0]   mem_address, mem_wdata;
  logic [3:0]    mem_byte_enable;
  logic          sel_o, mem_resp;
  logic [31:0]   mem_rdata;
  logic          sel4, resp4;
  logic [31:0]   rdata4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  perf_counter_unit #(.NUM_COUNTERS(NC), .CNT_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .count_en(count_en), .event_i(event_i),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .sel_o(sel_o), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  perf_counter_unit #(.NUM_COUNTERS(NC), .CNT_WIDTH(4), .BASE_ADDR(BASE)) dut4 (
    .clk(clk), .rst_n(rst_n), .count_en(count_en), .event_i(event_i),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .sel_o(sel4), .mem_rdata(rdata4), .mem_resp(resp4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic pulse(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      event_i      = '0;
      event_i[idx] = 1'b1;
      @(posedge clk); #1;
    end
    event_i = '0;
  endtask

  // Drives one request, waits (bounded) for mem_resp, captures both banks' read data.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [NC-1:0] ev,
                        output logic [31:0] rdata, output logic [31:0] rd4, output int lat);
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = wdata; mem_byte_enable = be; event_i = ev;
    lat = 0;
    do begin
      @(posedge clk); #1;
      event_i = '0;
      lat++;
    end while (!mem_resp && lat < 8);
    if (!mem_resp) chk("resp_timeout", 32'(mem_resp), 32'd1);
    rdata = mem_rdata;
    rd4   = rdata4;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d, d4;
    int          lat;
    access(1'b1, 1'b0, BASE + off, 32'h0, 4'h0, '0, d, d4, lat);
    chk(tag, d, exp);
  endtask

  task automatic wr_do(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] d, d4;
    int          lat;
    access(1'b0, 1'b1, BASE + off, data, be, '0, d, d4, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d4;
    int          lat;
    int          pulses;

    rst_n = 1'b0; count_en = 1'b1; event_i = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = BASE;
    mem_wdata = '0; mem_byte_enable = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset_resp", 32'(mem_resp), 32'd0);
    chk("reset_rdata", mem_rdata, 32'd0);
    chk("sel_hit", 32'(sel_o), 32'd1);
    mem_address = 32'hFFFF_FE00;
    #1 chk("sel_miss", 32'(sel_o), 32'd0);

    // Basic count and latency
    pulse(0, 5);
    access(1'b1, 1'b0, BASE, 32'h0, 4'h0, '0, d, d4, lat);
    chk("lat_read", 32'(lat), 32'd1);
    chk("cnt0_5", d, 32'd5);

    // Saturation at 4 bits vs 32-bit count
    pulse(7, 20);
    access(1'b1, 1'b0, BASE + 32'h1C, 32'h0, 4'h0, '0, d, d4, lat);
    chk("cnt7_w32", d, 32'd20);
    chk("cnt7_sat4", d4, 32'd15);

    // Write beats a same-edge event; read sees pre-increment value
    pulse(8, 3);
    access(1'b0, 1'b1, BASE + 32'h20, 32'h0, 4'hF, NC'(1) << 8, d, d4, lat);
    chk("lat_write", 32'(lat), 32'd1);
    rd_chk("wr_over_ev", 32'h20, 32'd0);
    pulse(8, 4);
    access(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, NC'(1) << 8, d, d4, lat);
    chk("rd_with_ev", d, 32'd4);
    rd_chk("after_rd_ev", 32'h20, 32'd5);

    // Byte-masked store
    wr_do(32'h08, 32'h1122_3344, 4'hF);
    wr_do(32'h08, 32'hAABB_CCDD, 4'h3);
    rd_chk("byte_mask", 32'h08, 32'h1122_CCDD);

    // Read+write together acts as a write and leaves mem_rdata alone
    access(1'b1, 1'b1, BASE + 32'h08, 32'h0000_0055, 4'hF, '0, d, d4, lat);
    chk("rdwr_rdata_held", d, 32'h1122_CCDD);
    rd_chk("rdwr_wrote", 32'h08, 32'h0000_0055);

    // Unmapped accesses
    access(1'b1, 1'b0, BASE + 32'h2C, 32'h0, 4'h0, '0, d, d4, lat);
    chk("unmap_idx11", d, 32'd0);
    chk("unmap_lat", 32'(lat), 32'd1);
    rd_chk("cnt0_again", 32'h00, 32'd5);
    rd_chk("unmap_misalign", 32'h02, 32'd0);
    wr_do(32'h2C, 32'hFFFF_FFFF, 4'hF);
    wr_do(32'h02, 32'hFFFF_FFFF, 4'hF);
    rd_chk("cnt0_untouched", 32'h00, 32'd5);
    rd_chk("cnt10_untouched", 32'h28, 32'd0);

    // Request held across the response cycle is serviced once
    mem_read = 1'b1; mem_address = BASE + 32'h1C;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mem_resp) pulses++;
      if (i == 1) mem_read = 1'b0;
    end
    chk("held_one_pulse", 32'(pulses), 32'd1);
    chk("held_rdata", mem_rdata, 32'd20);

    // Frozen counting, bus still live
    count_en = 1'b0;
    pulse(0, 10);
    rd_chk("count_en_off", 32'h00, 32'd5);
    count_en = 1'b1;

    // Reset during the response cycle
    mem_read = 1'b1; mem_address = BASE;
    @(posedge clk); #1;
    chk("resp_before_rst", 32'(mem_resp), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("resp_async_drop", 32'(mem_resp), 32'd0);
    chk("rdata_rst", mem_rdata, 32'd0);
    mem_read = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("post_rst_cnt0", 32'h00, 32'd0);
    rd_chk("post_rst_cnt8", 32'h20, 32'd0);
    access(1'b1, 1'b0, BASE + 32'h1C, 32'h0, 4'h0, '0, d, d4, lat);
    chk("post_rst_cnt7", d, 32'd0);
    chk("post_rst_cnt7_w4", d4, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
